// File: rtl/shell_launcher.sv
// Shell launcher: fires one shell per fire-button press, flies it on frame ticks,
// and strobes the opponent's collision input when the shell overlaps the target.
module shell_launcher #(
  parameter int FIELD_W   = 640,
  parameter int FIELD_H   = 480,
  parameter int SPEED     = 4,
  parameter int HIT_HALF  = 16,
  parameter int HIT_PULSE = 4,
  parameter int COOLDOWN  = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [1:0] tank_dir,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  logic       target_dead,
  output logic       shell_active,
  output logic [9:0] shell_x,
  output logic [9:0] shell_y,
  output logic       collision,
  output logic [7:0] shots_fired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_HIT,
    S_COOLDOWN
  } state_e;

  localparam logic [10:0] X_MAX    = 11'(FIELD_W - 1);
  localparam logic [10:0] Y_MAX    = 11'(FIELD_H - 1);
  localparam logic [10:0] STEP     = 11'(SPEED);
  localparam logic [10:0] HALF     = 11'(HIT_HALF);
  localparam logic [7:0]  PULSE_LAST = 8'(HIT_PULSE - 1);
  localparam logic [7:0]  COOL_LAST  = 8'(COOLDOWN - 1);

  state_e      state_q, state_d;
  logic        fire_prev_q, fire_prev_d;
  logic [1:0]  dir_q, dir_d;
  logic [7:0]  count_q, count_d;
  logic        shell_active_q, shell_active_d;
  logic [9:0]  shell_x_q, shell_x_d;
  logic [9:0]  shell_y_q, shell_y_d;
  logic        collision_q, collision_d;
  logic [7:0]  shots_fired_q, shots_fired_d;

  logic        fire_edge;
  logic [10:0] sx11, sy11, tx11, ty11;
  logic [10:0] dx, dy;
  logic [10:0] next_x, next_y;
  logic        overlap;
  logic        out_of_bounds;

  assign fire_edge = fire & ~fire_prev_q;

  // Distances and next position are evaluated in 11 bits so that a step below
  // zero wraps to a large value and is caught by the same upper-bound compare.
  assign sx11 = {1'b0, shell_x_q};
  assign sy11 = {1'b0, shell_y_q};
  assign tx11 = {1'b0, target_x};
  assign ty11 = {1'b0, target_y};
  assign dx   = (sx11 >= tx11) ? (sx11 - tx11) : (tx11 - sx11);
  assign dy   = (sy11 >= ty11) ? (sy11 - ty11) : (ty11 - sy11);
  assign overlap = (dx <= HALF) && (dy <= HALF);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_x = sx11;
    next_y = sy11;
    case (dir_q)
      2'd0: next_y = sy11 - STEP;
      2'd1: next_x = sx11 + STEP;
      2'd2: next_y = sy11 + STEP;
      2'd3: next_x = sx11 - STEP;
      default: ;
    endcase
  end

  assign out_of_bounds = (next_x > X_MAX) || (next_y > Y_MAX);

  always_comb begin
    state_d        = state_q;
    fire_prev_d    = fire;
    dir_d          = dir_q;
    count_d        = count_q;
    shell_active_d = shell_active_q;
    shell_x_d      = shell_x_q;
    shell_y_d      = shell_y_q;
    collision_d    = collision_q;
    shots_fired_d  = shots_fired_q;

    case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          state_d        = S_FLIGHT;
          shell_x_d      = tank_x;
          shell_y_d      = tank_y;
          dir_d          = tank_dir;
          shell_active_d = 1'b1;
          shots_fired_d  = shots_fired_q + 8'd1;
        end
      end

      S_FLIGHT: begin
        // Overlap on the current registered position wins over a move this cycle.
        if (overlap && !target_dead) begin
          state_d        = S_HIT;
          shell_active_d = 1'b0;
          collision_d    = 1'b1;
          count_d        = '0;
        end else if (frame_tick) begin
          if (out_of_bounds) begin
            state_d        = S_COOLDOWN;
            shell_active_d = 1'b0;
            count_d        = '0;
          end else begin
            shell_x_d = next_x[9:0];
            shell_y_d = next_y[9:0];
          end
        end
      end

      S_HIT: begin
        if (count_q == PULSE_LAST) begin
          state_d     = S_COOLDOWN;
          collision_d = 1'b0;
          count_d     = '0;
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      S_COOLDOWN: begin
        if (frame_tick) begin
          if (count_q == COOL_LAST) begin
            state_d = S_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      fire_prev_q    <= 1'b0;
      dir_q          <= 2'd0;
      count_q        <= '0;
      shell_active_q <= 1'b0;
      shell_x_q      <= '0;
      shell_y_q      <= '0;
      collision_q    <= 1'b0;
      shots_fired_q  <= '0;
    end else begin
      state_q        <= state_d;
      fire_prev_q    <= fire_prev_d;
      dir_q          <= dir_d;
      count_q        <= count_d;
      shell_active_q <= shell_active_d;
      shell_x_q      <= shell_x_d;
      shell_y_q      <= shell_y_d;
      collision_q    <= collision_d;
      shots_fired_q  <= shots_fired_d;
    end
  end

  assign shell_active = shell_active_q;
  assign shell_x      = shell_x_q;
  assign shell_y      = shell_y_q;
  assign collision    = collision_q;
  assign shots_fired  = shots_fired_q;

endmodule

// File: tb/tb_shell_launcher.sv
// Directed bench for shell_launcher: a table of launch scenarios plus
// hand-written sequences for held fire, cooldown gating and async reset.
module tb_shell_launcher;

  localparam int COOL = 30;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       fire;
  logic [9:0] tank_x, tank_y, target_x, target_y;
  logic [1:0] tank_dir;
  logic       target_dead;
  logic       shell_active;
  logic [9:0] shell_x, shell_y;
  logic       collision;
  logic [7:0] shots_fired;

  shell_launcher dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .fire        (fire),
    .tank_x      (tank_x),
    .tank_y      (tank_y),
    .tank_dir    (tank_dir),
    .target_x    (target_x),
    .target_y    (target_y),
    .target_dead (target_dead),
    .shell_active(shell_active),
    .shell_x     (shell_x),
    .shell_y     (shell_y),
    .collision   (collision),
    .shots_fired (shots_fired)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit col_seen;
  logic [7:0] exp_shots;

  always @(negedge clock) if (collision === 1'b1) col_seen = 1'b1;

  typedef struct {
    string      name;
    logic [9:0] tx, ty;
    logic [1:0] dir;
    logic [9:0] gx, gy;
    logic       dead;
    logic       exp_hit;
    int         exp_ticks;
    logic [9:0] exp_x, exp_y;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic tick);
    frame_tick = tick;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic press();
    fire = 1'b1;
    step(1'b0);
    fire = 1'b0;
  endtask

  // Alternates a no-tick cycle (overlap check) with a tick cycle (move) until the shell ends.
  task automatic run_flight(output int ticks);
    ticks = 0;
    for (int g = 0; g < 1000; g++) begin
      step(1'b0);
      if (!shell_active) break;
      step(1'b1);
      ticks++;
    end
  endtask

  initial begin
    int ticks;
    int width;

    vecs[0] = '{"hit_right",    10'd100, 10'd100, 2'd1, 10'd200, 10'd100, 1'b0, 1'b1, 21, 10'd184, 10'd100};
    vecs[1] = '{"bounds_left",  10'd2,   10'd50,  2'd3, 10'd400, 10'd400, 1'b0, 1'b0, 1,  10'd2,   10'd50};
    vecs[2] = '{"dead_pass",    10'd600, 10'd200, 2'd1, 10'd620, 10'd200, 1'b1, 1'b0, 10, 10'd636, 10'd200};
    vecs[3] = '{"adjacent",     10'd300, 10'd300, 2'd1, 10'd310, 10'd300, 1'b0, 1'b1, 0,  10'd300, 10'd300};
    vecs[4] = '{"hit_up",       10'd50,  10'd100, 2'd0, 10'd50,  10'd40,  1'b0, 1'b1, 11, 10'd50,  10'd56};
    vecs[5] = '{"bounds_down",  10'd10,  10'd470, 2'd2, 10'd600, 10'd10,  1'b0, 1'b0, 3,  10'd10,  10'd478};

    reset_n = 1'b0;
    frame_tick = 1'b0;
    fire = 1'b0;
    tank_x = '0; tank_y = '0; tank_dir = '0;
    target_x = 10'd1000; target_y = 10'd1000; target_dead = 1'b0;
    exp_shots = '0;
    #12;
    check("reset_active", 32'(shell_active), 0);
    check("reset_x", 32'(shell_x), 0);
    check("reset_y", 32'(shell_y), 0);
    check("reset_collision", 32'(collision), 0);
    check("reset_shots", 32'(shots_fired), 0);
    reset_n = 1'b1;
    step(1'b0);

    for (int i = 0; i < 6; i++) begin
      tank_x = vecs[i].tx; tank_y = vecs[i].ty; tank_dir = vecs[i].dir;
      target_x = vecs[i].gx; target_y = vecs[i].gy; target_dead = vecs[i].dead;
      col_seen = 1'b0;
      press();
      exp_shots = exp_shots + 8'd1;
      // Tank moving after launch must not affect the shell.
      tank_x = 10'd5; tank_y = 10'd5; tank_dir = ~vecs[i].dir;
      check({vecs[i].name, "_launch_active"}, 32'(shell_active), 1);
      check({vecs[i].name, "_launch_x"}, 32'(shell_x), 32'(vecs[i].tx));
      check({vecs[i].name, "_launch_y"}, 32'(shell_y), 32'(vecs[i].ty));
      check({vecs[i].name, "_shots"}, 32'(shots_fired), 32'(exp_shots));
      run_flight(ticks);
      check({vecs[i].name, "_ticks"}, 32'(ticks), 32'(vecs[i].exp_ticks));
      check({vecs[i].name, "_final_x"}, 32'(shell_x), 32'(vecs[i].exp_x));
      check({vecs[i].name, "_final_y"}, 32'(shell_y), 32'(vecs[i].exp_y));
      check({vecs[i].name, "_col_at_end"}, 32'(collision), 32'(vecs[i].exp_hit));
      width = 0;
      while (collision && width < 10) begin
        width++;
        step(1'b0);
      end
      check({vecs[i].name, "_pulse_width"}, 32'(width), vecs[i].exp_hit ? 4 : 0);
      check({vecs[i].name, "_col_seen"}, 32'(col_seen), 32'(vecs[i].exp_hit));
      repeat (COOL) step(1'b1);
    end

    // Fire held for 200 frames: exactly one shot.
    tank_x = 10'd100; tank_y = 10'd300; tank_dir = 2'd1;
    target_x = 10'd600; target_y = 10'd10; target_dead = 1'b0;
    fire = 1'b1;
    step(1'b0);
    exp_shots = exp_shots + 8'd1;
    for (int i = 0; i < 200; i++) step(1'b1);
    check("held_shots", 32'(shots_fired), 32'(exp_shots));
    check("held_idle", 32'(shell_active), 0);
    fire = 1'b0;
    step(1'b0);
    press();
    exp_shots = exp_shots + 8'd1;
    check("repress_active", 32'(shell_active), 1);
    check("repress_shots", 32'(shots_fired), 32'(exp_shots));
    step(1'b0);
    press();
    check("flight_edge_dropped", 32'(shots_fired), 32'(exp_shots));
    run_flight(ticks);
    check("long_flight_ticks", 32'(ticks), 135);
    check("long_flight_x", 32'(shell_x), 636);

    // Cooldown gating: an edge on tick 29 is dropped, after tick 30 it is accepted.
    repeat (COOL - 1) step(1'b1);
    press();
    check("cool_edge_active", 32'(shell_active), 0);
    check("cool_edge_shots", 32'(shots_fired), 32'(exp_shots));
    step(1'b1);
    press();
    exp_shots = exp_shots + 8'd1;
    check("post_cool_active", 32'(shell_active), 1);
    check("post_cool_shots", 32'(shots_fired), 32'(exp_shots));

    // Asynchronous reset mid-flight.
    repeat (3) step(1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_flight_active", 32'(shell_active), 0);
    check("rst_flight_shots", 32'(shots_fired), 0);
    check("rst_flight_x", 32'(shell_x), 0);
    check("rst_flight_col", 32'(collision), 0);
    reset_n = 1'b1;
    step(1'b0);
    exp_shots = '0;

    // Asynchronous reset mid-pulse, with target_dead rising during the pulse first.
    tank_x = 10'd300; tank_y = 10'd300; tank_dir = 2'd1;
    target_x = 10'd310; target_y = 10'd300; target_dead = 1'b0;
    press();
    step(1'b0);
    check("pulse_start_col", 32'(collision), 1);
    target_dead = 1'b1;
    step(1'b0);
    check("pulse_dead_col", 32'(collision), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pulse_col", 32'(collision), 0);
    check("rst_pulse_shots", 32'(shots_fired), 0);
    reset_n = 1'b1;
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
